deser_queue: RTL and testbench
==============================

DESER_QUEUE -- requirements
Module: deser_queue

Interface
REQ-001 The block SHALL have parameter DATA_W, default 8, meaning word width in bits (>=2).
REQ-002 The block SHALL have parameter DEPTH, default 8, meaning queue entries (power of two, >=2).
REQ-003 The block SHALL have parameter MSB_FIRST, default 1, meaning the first serial bit lands in bit DATA_W-1 (0: lands in bit 0).
REQ-004 The block SHALL have parameter OVF_MODE, default OVF_BLOCK, meaning the full-queue policy (OVF_BLOCK or OVF_DROP).
REQ-005 The block SHALL have port clock1M, input, 1, meaning the single system clock, rising edge.
REQ-006 The block SHALL have port reset, input, 1, meaning asynchronous active-high reset.
REQ-007 The block SHALL have port data_in, input, 1, meaning the serial data bit.
REQ-008 The block SHALL have port write_in, input, 1, meaning the bit strobe; each rising edge captures one bit.
REQ-009 The block SHALL have port dequeue_in, input, 1, meaning the pop request; each rising edge pops one word.
REQ-010 The block SHALL have port data_out, output, DATA_W, meaning the last word popped.
REQ-011 The block SHALL have port status_out, output, 1, meaning 1 = a complete word is pending and write strobes are ignored.
REQ-012 The block SHALL have port count_out, output, $clog2(DEPTH+1), meaning current queue occupancy.
REQ-013 The block SHALL have ports full_out and empty_out, output, 1 each, meaning count_out==DEPTH and count_out==0.
REQ-014 The block SHALL have port overflow_out, output, 1, meaning sticky: a word was dropped (OVF_DROP only).

Function
REQ-015 data_in, write_in and dequeue_in SHALL each pass through a 2-flop synchronizer; data_in SHALL be delayed identically to write_in.
REQ-016 A strobe event SHALL be synchronized-high AND previous-synchronized-low; an event SHALL act on the 3rd rising clock1M edge after the input rises; a held level SHALL yield exactly one event.
REQ-017 In state COLLECT, each write event SHALL shift in one bit: left shift with new bit at LSB if MSB_FIRST=1, else right shift with new bit at MSB; a bit counter SHALL increment.
REQ-018 On the DATA_W-th bit, the FSM SHALL enter PEND, set status_out=1, and clear the bit counter.
REQ-019 In PEND, write events SHALL be ignored and discarded.
REQ-020 In PEND, if not full, or full with a pop event on the same edge, the word SHALL be pushed on that edge and the FSM SHALL return to COLLECT; status_out is high for exactly 1 cycle.
REQ-021 In PEND, if full with no pop and OVF_MODE=OVF_BLOCK, the FSM SHALL stay in PEND until space exists, then push on the edge space appears.
REQ-022 In PEND, if full with no pop and OVF_MODE=OVF_DROP, the word SHALL be discarded, overflow_out SHALL be set (cleared only by reset), and the FSM SHALL return to COLLECT.
REQ-023 On a pop event when not empty, data_out SHALL take the head word on that edge (registered, 1-edge latency from the event) and the read pointer SHALL advance.
REQ-024 A pop event when empty SHALL leave data_out, pointers and count unchanged.
REQ-025 Simultaneous push and pop SHALL leave count unchanged, including when full; pointers SHALL wrap modulo DEPTH.
REQ-026 full_out, empty_out and count_out SHALL be registered-consistent with each other on every cycle.

Reset
REQ-027 Reset asserted SHALL immediately set: data_out=0, status_out=0, count_out=0, empty_out=1, full_out=0, overflow_out=0, FSM=COLLECT, bit counter=0, pointers=0, synchronizers=0.
REQ-028 Reset mid-word or mid-PEND SHALL discard the partial or pending word; queue contents SHALL be unobservable after reset.

Structure
REQ-029 Package deser_pkg SHALL hold the FSM state typedef (COLLECT, PEND) and the ovf_mode_t enum (OVF_BLOCK, OVF_DROP).
REQ-030 Sub-module sync_edge (2-flop sync + rising-edge pulse, async reset) SHALL be instantiated for write_in and dequeue_in; data_in SHALL use its sync path only.
REQ-031 Storage SHALL be a flop array of DEPTH x DATA_W.

Verification
REQ-032 After reset, send 10101010 (MSB_FIRST=1), then pop -> status pulses 1 cycle; count 1->0; data_out=8'hAA.
REQ-033 MSB_FIRST=0, send bits 1,1,1,1,0,0,0,0, then pop -> data_out=8'h0F.
REQ-034 OVF_BLOCK: send 9 words -> count=8, full=1, status_out stays 1; pop 4 -> first data_out=word0, 9th word enters, final count=5.
REQ-035 OVF_DROP: send 9 words -> 9th discarded, overflow_out=1, status_out=0, count=8; pop 8 -> words 0..7 in order, empty=1.
REQ-036 Full queue with 9th word pending; pop on the push edge -> count stays 8. Separately, pop when empty -> data_out unchanged. Separately, write_in held high 50 cycles -> exactly one bit shifted.
REQ-037 Reset asserted after 4 bits of a word -> all outputs at reset values; next 8 bits form a clean new word.

Source files
------------

// File: rtl/deser_pkg.sv
// Shared types for the serial-to-parallel word queue: FSM states and the
// policy applied when a completed word meets a full queue.
package deser_pkg;

  typedef enum logic {
    COLLECT = 1'b0,
    PEND    = 1'b1
  } state_t;

  typedef enum logic {
    OVF_BLOCK = 1'b0,
    OVF_DROP  = 1'b1
  } ovf_mode_t;

endpackage

// File: rtl/sync_edge.sv
// Two-flop synchronizer followed by a rising-edge detector. The pulse is
// asserted for one cycle when the synchronized level goes from 0 to 1, so a
// held input produces a single pulse.
module sync_edge (
  input  logic clk,
  input  logic rst,
  input  logic i_in,
  output logic o_sync,
  output logic o_pulse
);

  logic r_meta;
  logic r_sync;
  logic r_prev;

  // Synchronizer chain plus one extra stage holding the previous level.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_meta <= 1'b0;
      r_sync <= 1'b0;
      r_prev <= 1'b0;
    end else begin
      r_meta <= i_in;
      r_sync <= r_meta;
      r_prev <= r_sync;
    end
  end

  assign o_sync  = r_sync;
  assign o_pulse = r_sync & ~r_prev;

endmodule

// File: rtl/deser_queue.sv
// Serial bit collector feeding a small word queue. Bits arrive on write_in
// strobes, a completed word waits in PEND until it can be pushed (or is
// dropped when the queue is full in drop mode), and dequeue_in strobes pop
// words onto data_out.
module deser_queue
  import deser_pkg::*;
#(
  parameter int        DATA_W    = 8,
  parameter int        DEPTH     = 8,
  parameter bit        MSB_FIRST = 1'b1,
  parameter ovf_mode_t OVF_MODE  = OVF_BLOCK
) (
  input  logic                           clock1M,
  input  logic                           reset,
  input  logic                           data_in,
  input  logic                           write_in,
  input  logic                           dequeue_in,
  output logic [DATA_W-1:0]              data_out,
  output logic                           status_out,
  output logic [$clog2(DEPTH+1)-1:0]     count_out,
  output logic                           full_out,
  output logic                           empty_out,
  output logic                           overflow_out
);

  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int BIT_W = $clog2(DATA_W);

  localparam logic [CNT_W-1:0] DEPTH_C  = CNT_W'(DEPTH);
  localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(DATA_W - 1);

  // Synchronized inputs and strobe events
  logic w_data_sync;
  logic w_unused_data_pulse;
  logic w_wr_ev;
  logic w_unused_wr_sync;
  logic w_pop_req;
  logic w_unused_pop_sync;

  // Bit collection
  state_t              r_state;
  state_t              w_state_next;
  logic [DATA_W-1:0]   r_shift;
  logic [DATA_W-1:0]   w_shifted;
  logic [BIT_W-1:0]    r_bit_cnt;

  // Queue
  logic [DATA_W-1:0]   r_mem [DEPTH];
  logic [PTR_W-1:0]    r_wr_ptr;
  logic [PTR_W-1:0]    r_rd_ptr;
  logic [CNT_W-1:0]    r_count;
  logic [CNT_W-1:0]    w_count_next;
  logic                r_full;
  logic                r_empty;
  logic [DATA_W-1:0]   r_data;
  logic                r_ovf;

  logic w_push;
  logic w_drop;
  logic w_pop;

  // data_in only needs the level path; its pulse is left unused so that it
  // is delayed exactly like the strobe it is qualified by.
  sync_edge u_sync_data (
    .clk     (clock1M),
    .rst     (reset),
    .i_in    (data_in),
    .o_sync  (w_data_sync),
    .o_pulse (w_unused_data_pulse)
  );

  sync_edge u_sync_write (
    .clk     (clock1M),
    .rst     (reset),
    .i_in    (write_in),
    .o_sync  (w_unused_wr_sync),
    .o_pulse (w_wr_ev)
  );

  sync_edge u_sync_pop (
    .clk     (clock1M),
    .rst     (reset),
    .i_in    (dequeue_in),
    .o_sync  (w_unused_pop_sync),
    .o_pulse (w_pop_req)
  );

  // Shift direction decides which end of the word the first bit ends up in.
  generate
    if (MSB_FIRST) begin : g_msb_first
      assign w_shifted = {r_shift[DATA_W-2:0], w_data_sync};
    end else begin : g_lsb_first
      assign w_shifted = {w_data_sync, r_shift[DATA_W-1:1]};
    end
  endgenerate

  // A pop on an empty queue is a no-op.
  assign w_pop = w_pop_req & ~r_empty;

  // Next-state and push/drop decisions; a pop on the same edge frees the
  // slot a full queue needs, so the pending word may go in alongside it.
  always_comb begin
    w_state_next = r_state;
    w_push       = 1'b0;
    w_drop       = 1'b0;
    case (r_state)
      COLLECT: begin
        if (w_wr_ev && (r_bit_cnt == LAST_BIT)) begin
          w_state_next = PEND;
        end
      end
      PEND: begin
        if (!r_full || w_pop) begin
          w_push       = 1'b1;
          w_state_next = COLLECT;
        end else if (OVF_MODE == OVF_DROP) begin
          w_drop       = 1'b1;
          w_state_next = COLLECT;
        end
      end
      default: w_state_next = COLLECT;
    endcase
  end

  // FSM state register.
  always_ff @(posedge clock1M or posedge reset) begin
    if (reset) begin
      r_state <= COLLECT;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Shift in one bit per write event while collecting; strobes in PEND are lost.
  always_ff @(posedge clock1M or posedge reset) begin
    if (reset) begin
      r_shift   <= '0;
      r_bit_cnt <= '0;
    end else if ((r_state == COLLECT) && w_wr_ev) begin
      r_shift   <= w_shifted;
      r_bit_cnt <= (r_bit_cnt == LAST_BIT) ? '0 : r_bit_cnt + BIT_W'(1);
    end
  end

  // Storage array; contents are never reset since pointers define validity.
  always_ff @(posedge clock1M) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= r_shift;
    end
  end

  // Occupancy after this edge's push/pop.
  always_comb begin
    w_count_next = r_count;
    case ({w_push, w_pop})
      2'b10:   w_count_next = r_count + CNT_W'(1);
      2'b01:   w_count_next = r_count - CNT_W'(1);
      default: w_count_next = r_count;
    endcase
  end

  // Pointers, occupancy and flags all update from the same next count.
  always_ff @(posedge clock1M or posedge reset) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_full   <= 1'b0;
      r_empty  <= 1'b1;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      r_count <= w_count_next;
      r_full  <= (w_count_next == DEPTH_C);
      r_empty <= (w_count_next == '0);
    end
  end

  // Registered read port and sticky overflow flag.
  always_ff @(posedge clock1M or posedge reset) begin
    if (reset) begin
      r_data <= '0;
      r_ovf  <= 1'b0;
    end else begin
      if (w_pop)  r_data <= r_mem[r_rd_ptr];
      if (w_drop) r_ovf  <= 1'b1;
    end
  end

  assign data_out     = r_data;
  assign status_out   = (r_state == PEND);
  assign count_out    = r_count;
  assign full_out     = r_full;
  assign empty_out    = r_empty;
  assign overflow_out = r_ovf;

endmodule

// File: tb/tb_deser_queue.sv
// Scoreboard bench for deser_queue. Three instances share the inputs:
// MSB-first/block, LSB-first/block and MSB-first/drop. 'sel' picks which one
// the checks look at. Pops push their expected word into a queue; a monitor
// process samples data_out three edges after each dequeue strobe rises.
module tb_deser_queue;
  import deser_pkg::*;

  logic clock1M    = 1'b0;
  logic reset      = 1'b0;
  logic data_in    = 1'b0;
  logic write_in   = 1'b0;
  logic dequeue_in = 1'b0;

  logic [7:0] d0, d1, d2;
  logic       st0, st1, st2;
  logic [3:0] c0, c1, c2;
  logic       f0, f1, f2;
  logic       e0, e1, e2;
  logic       o0, o1, o2;

  always #5 clock1M = ~clock1M;

  deser_queue #(.DATA_W(8), .DEPTH(8), .MSB_FIRST(1'b1), .OVF_MODE(OVF_BLOCK)) u_msb (
    .clock1M(clock1M), .reset(reset), .data_in(data_in), .write_in(write_in),
    .dequeue_in(dequeue_in), .data_out(d0), .status_out(st0), .count_out(c0),
    .full_out(f0), .empty_out(e0), .overflow_out(o0));

  deser_queue #(.DATA_W(8), .DEPTH(8), .MSB_FIRST(1'b0), .OVF_MODE(OVF_BLOCK)) u_lsb (
    .clock1M(clock1M), .reset(reset), .data_in(data_in), .write_in(write_in),
    .dequeue_in(dequeue_in), .data_out(d1), .status_out(st1), .count_out(c1),
    .full_out(f1), .empty_out(e1), .overflow_out(o1));

  deser_queue #(.DATA_W(8), .DEPTH(8), .MSB_FIRST(1'b1), .OVF_MODE(OVF_DROP)) u_drop (
    .clock1M(clock1M), .reset(reset), .data_in(data_in), .write_in(write_in),
    .dequeue_in(dequeue_in), .data_out(d2), .status_out(st2), .count_out(c2),
    .full_out(f2), .empty_out(e2), .overflow_out(o2));

  int sel = 0;
  int total = 0;
  int bad = 0;
  int stat_cycles = 0;

  typedef struct {
    int         sel;
    logic [7:0] d;
  } exp_t;
  exp_t sb[$];

  logic [7:0] cur_data;
  logic       cur_status, cur_full, cur_empty, cur_ovf;
  logic [3:0] cur_count;

  always_comb begin
    cur_data = d0; cur_status = st0; cur_count = c0;
    cur_full = f0; cur_empty = e0; cur_ovf = o0;
    case (sel)
      1: begin
        cur_data = d1; cur_status = st1; cur_count = c1;
        cur_full = f1; cur_empty = e1; cur_ovf = o1;
      end
      2: begin
        cur_data = d2; cur_status = st2; cur_count = c2;
        cur_full = f2; cur_empty = e2; cur_ovf = o2;
      end
      default: ;
    endcase
  end

  // Cycles the selected instance spends with a word pending.
  always @(negedge clock1M) begin
    if (cur_status) stat_cycles = stat_cycles + 1;
  end

  task automatic chk(input string name, input int act, input int exp);
    total = total + 1;
    if (act != exp) begin
      bad = bad + 1;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end else begin
      $display("ok   %s: 0x%0h", name, act);
    end
  endtask

  task automatic send_bit(input logic b);
    @(negedge clock1M);
    data_in  = b;
    write_in = 1'b1;
    repeat (2) @(negedge clock1M);
    write_in = 1'b0;
    repeat (2) @(negedge clock1M);
  endtask

  task automatic send_word(input logic [7:0] w);
    for (int i = 7; i >= 0; i--) send_bit(w[i]);
  endtask

  task automatic pop_exp(input logic [7:0] e);
    sb.push_back('{sel: sel, d: e});
    @(negedge clock1M);
    dequeue_in = 1'b1;
    repeat (2) @(negedge clock1M);
    dequeue_in = 1'b0;
    repeat (2) @(negedge clock1M);
  endtask

  task automatic do_reset();
    @(negedge clock1M);
    reset = 1'b1;
    repeat (2) @(negedge clock1M);
    reset = 1'b0;
    @(negedge clock1M);
  endtask

  // Monitor: the pop event acts on the third rising edge after the strobe.
  initial begin
    exp_t e;
    forever begin
      @(posedge dequeue_in);
      repeat (3) @(posedge clock1M);
      #1;
      total = total + 1;
      if (sb.size() == 0) begin
        bad = bad + 1;
        $display("FAIL sb_pop: got pop with no expectation (t=%0t)", $time);
      end else begin
        e = sb.pop_front();
        total = total - 1;
        chk($sformatf("data_out[inst%0d]", e.sel), int'(sel == 0 ? d0 : (sel == 1 ? d1 : d2)), int'(e.d));
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] lsb_bits;

    // Reset values
    sel = 0;
    do_reset();
    chk("rst_data", cur_data, 0);
    chk("rst_status", cur_status, 0);
    chk("rst_count", cur_count, 0);
    chk("rst_empty", cur_empty, 1);
    chk("rst_full", cur_full, 0);
    chk("rst_ovf", cur_ovf, 0);

    // MSB-first word 0xAA, status pulses one cycle
    stat_cycles = 0;
    send_word(8'hAA);
    chk("aa_status_cycles", stat_cycles, 1);
    chk("aa_count", cur_count, 1);
    chk("aa_empty", cur_empty, 0);
    pop_exp(8'hAA);
    chk("aa_count_after_pop", cur_count, 0);
    chk("aa_empty_after_pop", cur_empty, 1);

    // LSB-first: bits 1,1,1,1,0,0,0,0 -> 0x0F
    sel = 1;
    do_reset();
    lsb_bits = 8'b1111_0000;
    for (int i = 7; i >= 0; i--) send_bit(lsb_bits[i]);
    chk("lsb_count", cur_count, 1);
    pop_exp(8'h0F);

    // Block mode: nine words, ninth waits in PEND
    sel = 0;
    do_reset();
    for (int i = 0; i < 9; i++) send_word(8'hA0 + 8'(i));
    chk("blk_count_full", cur_count, 8);
    chk("blk_full", cur_full, 1);
    chk("blk_status_pending", cur_status, 1);
    pop_exp(8'hA0);
    chk("blk_count_push_pop", cur_count, 8);
    chk("blk_status_cleared", cur_status, 0);
    for (int i = 1; i < 4; i++) pop_exp(8'hA0 + 8'(i));
    chk("blk_count_final", cur_count, 5);
    chk("blk_full_final", cur_full, 0);
    for (int i = 4; i < 9; i++) pop_exp(8'hA0 + 8'(i));
    chk("blk_empty_drained", cur_empty, 1);

    // Drop mode: ninth word discarded
    sel = 2;
    do_reset();
    for (int i = 0; i < 9; i++) send_word(8'hB0 + 8'(i));
    chk("drop_ovf", cur_ovf, 1);
    chk("drop_status", cur_status, 0);
    chk("drop_count", cur_count, 8);
    chk("drop_full", cur_full, 1);
    for (int i = 0; i < 8; i++) pop_exp(8'hB0 + 8'(i));
    chk("drop_empty", cur_empty, 1);
    chk("drop_ovf_sticky", cur_ovf, 1);

    // Pop while empty leaves data_out and count alone
    pop_exp(8'hB7);
    chk("empty_pop_count", cur_count, 0);
    chk("empty_pop_empty", cur_empty, 1);

    // Held strobe yields one bit: 1 (held) + 0000001 -> 0x81
    sel = 0;
    do_reset();
    @(negedge clock1M);
    data_in  = 1'b1;
    write_in = 1'b1;
    repeat (50) @(negedge clock1M);
    write_in = 1'b0;
    repeat (2) @(negedge clock1M);
    for (int i = 0; i < 6; i++) send_bit(1'b0);
    chk("hold_count_7bits", cur_count, 0);
    send_bit(1'b1);
    chk("hold_count_8bits", cur_count, 1);
    pop_exp(8'h81);

    // Reset in the middle of a word
    send_word(8'h5A);
    pop_exp(8'h5A);
    send_word(8'h3C);
    chk("midrst_pre_count", cur_count, 1);
    for (int i = 0; i < 4; i++) send_bit(1'b1);
    @(negedge clock1M);
    #2 reset = 1'b1;
    #1;
    chk("midrst_data", cur_data, 0);
    chk("midrst_count", cur_count, 0);
    chk("midrst_empty", cur_empty, 1);
    chk("midrst_status", cur_status, 0);
    chk("midrst_full", cur_full, 0);
    @(negedge clock1M);
    reset = 1'b0;
    repeat (2) @(negedge clock1M);
    send_word(8'h96);
    chk("midrst_new_count", cur_count, 1);
    pop_exp(8'h96);

    repeat (5) @(negedge clock1M);
    chk("sb_drained", sb.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
